msrv32_wr_en_ctrl: RTL and testbench
====================================

Name: msrv32_wr_en_ctrl

Overview:
- Parametrised, registered write-enable controller for the msrv32 write-back stage.
- Generalises the flush-gated integer/CSR enable pair to NUM_PORTS register-file write channels.
- Adds a programmable post-flush kill window, stall handling, x0-write suppression and a saturating killed-write counter.
- Sits between the WB pipeline register and the integer/CSR/extension register files; outputs drive the file write ports directly.

Parameters:
- NUM_PORTS, 2, number of write channels; port 0 = integer file, port 1 = CSR file, higher = extension files.
- ADDR_W, 12, address width per channel; integer file uses the low 5 bits.
- DATA_W, 32, data width per channel.
- KILL_CYCLES, 1, extra cycles after a flush cycle during which all write requests are dropped; 0 = flush cycle only.
- ZERO_SUPPRESS_MASK, 'b01, per-port bit; if set, a request with address 0 is dropped (integer x0).
- CNT_W, 16, width of the killed-write counter.

Ports:
- clk_in, input, 1, core clock, rising edge.
- rst_n_in, input, 1, reset, asynchronous, active-low.
- flush_in, input, 1, pipeline flush from the trap/branch unit.
- stall_in, input, 1, WB stage stalled this cycle.
- wr_en_req_in, input, NUM_PORTS, per-channel write request.
- wr_addr_in, input, NUM_PORTS*ADDR_W, packed addresses; channel i at [i*ADDR_W +: ADDR_W].
- wr_data_in, input, NUM_PORTS*DATA_W, packed data; same packing.
- wr_en_out, output, NUM_PORTS, registered per-channel write enable.
- wr_addr_out, output, NUM_PORTS*ADDR_W, registered addresses.
- wr_data_out, output, NUM_PORTS*DATA_W, registered data.
- kill_active_out, output, 1, kill window active (kill_cnt != 0).
- killed_cnt_out, output, CNT_W, saturating count of dropped requests.

Behaviour:
- Reset (rst_n_in=0, asynchronous): wr_en_out=0, wr_addr_out=0, wr_data_out=0, kill_cnt=0, kill_active_out=0, killed_cnt_out=0. Deassertion is synchronous to clk_in via the external reset synchroniser.
- Latency: outputs at edge t+1 reflect inputs sampled at edge t. No combinational path from input to output.
- Kill counter (width $clog2(KILL_CYCLES+1), minimum 1):
  - flush_in=1 loads KILL_CYCLES. This includes flush during an active window (reload, not extend-add).
  - Otherwise, if kill_cnt != 0, it decrements by 1 each cycle, regardless of stall_in.
- kill = flush_in | (kill_cnt != 0).
- Per-channel enable: wr_en_out[i] <= wr_en_req_in[i] & ~kill & ~stall_in & ~(ZERO_SUPPRESS_MASK[i] & (addr_i == 0)).
- Address and data registers:
  - Load every cycle when stall_in=0.
  - Hold when stall_in=1; enables are forced 0 during stall so no write is repeated.
- Drop counting:
  - A "drop" is a channel with wr_en_req_in[i]=1 and kill=1 and stall_in=0.
  - killed_cnt_out increases by the number of drops that cycle (0..NUM_PORTS).
  - It saturates at 2^CNT_W-1 and never wraps.
  - x0 suppression and stall are not counted as drops.
- Simultaneous flush_in and stall_in: the counter loads and nothing is counted (stall has priority for counting).
- Reset mid-window clears kill_cnt immediately. The first cycle after reset has no kill.
- kill_active_out is registered and equals (kill_cnt != 0).

Test Plan:
- Reset: hold rst_n_in=0 with req=2'b11, then release -> all outputs 0 during reset. First request with addr0=5, data0=32'hDEAD produces wr_en_out=2'b01 one cycle later, with wr_addr/wr_data matching.
- Flush window, KILL_CYCLES=1: req=2'b11 every cycle, flush_in pulse at cycle 10 -> wr_en_out=0 at cycles 11 and 12, 2'b11 at cycle 13. kill_active_out=1 at cycle 11 only. killed_cnt_out=4.
- Re-flush: KILL_CYCLES=3, flush at cycles 10 and 12 -> enables suppressed through cycle 16. Requests resume at the cycle-17 output.
- Stall hold: stall_in=1 for 3 cycles with changing inputs -> wr_en_out=0, addr/data frozen at pre-stall values, killed_cnt_out unchanged.
- x0 suppression: req on port0 with addr=0 -> wr_en_out[0]=0 and counter unchanged. The same request on port1 with addr=0 -> wr_en_out[1]=1.
- Saturation: CNT_W=4, 20 killed requests on one port -> killed_cnt_out stops at 15. Asynchronous reset mid-window clears the counter and kill state within the same cycle.

Source files
------------

// File: rtl/msrv32_wr_en_ctrl.sv
// Registered write-enable controller for the msrv32 write-back stage.
// Gates NUM_PORTS register-file write channels with flush/kill-window, stall and x0 suppression.
module msrv32_wr_en_ctrl #(
    parameter int unsigned          NUM_PORTS          = 2,
    parameter int unsigned          ADDR_W             = 12,
    parameter int unsigned          DATA_W             = 32,
    parameter int unsigned          KILL_CYCLES        = 1,
    parameter logic [NUM_PORTS-1:0] ZERO_SUPPRESS_MASK = 'b01,
    parameter int unsigned          CNT_W              = 16
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          flush_in,
    input  logic                          stall_in,
    input  logic [NUM_PORTS-1:0]          wr_en_req_in,
    input  logic [NUM_PORTS*ADDR_W-1:0]   wr_addr_in,
    input  logic [NUM_PORTS*DATA_W-1:0]   wr_data_in,
    output logic [NUM_PORTS-1:0]          wr_en_out,
    output logic [NUM_PORTS*ADDR_W-1:0]   wr_addr_out,
    output logic [NUM_PORTS*DATA_W-1:0]   wr_data_out,
    output logic                          kill_active_out,
    output logic [CNT_W-1:0]              killed_cnt_out
);

    localparam int unsigned KW = (KILL_CYCLES == 0) ? 1 : $clog2(KILL_CYCLES + 1);
    localparam int unsigned DW = $clog2(NUM_PORTS + 1);
    localparam int unsigned SW = CNT_W + 1;
    localparam logic [KW-1:0] KILL_LOAD = KW'(KILL_CYCLES);

    logic [KW-1:0]               kill_cnt_q, kill_cnt_d;
    logic                        kill_active_q;
    logic [NUM_PORTS-1:0]        wr_en_q, wr_en_d;
    logic [NUM_PORTS*ADDR_W-1:0] wr_addr_q;
    logic [NUM_PORTS*DATA_W-1:0] wr_data_q;
    logic [CNT_W-1:0]            killed_cnt_q, killed_cnt_d;

    logic                        kill;
    logic [NUM_PORTS-1:0]        zero_sup;
    logic [NUM_PORTS-1:0]        drop_vec;
    logic [DW-1:0]               drops;
    logic [SW-1:0]               cnt_sum;

    // A flush reloads the window rather than extending it.
    always_comb begin
        kill       = flush_in | (kill_cnt_q != '0);
        kill_cnt_d = kill_cnt_q;
        if (flush_in) begin
            kill_cnt_d = KILL_LOAD;
        end else if (kill_cnt_q != '0) begin
            kill_cnt_d = kill_cnt_q - KW'(1);
        end
    end

    always_comb begin
        zero_sup = '0;
        wr_en_d  = '0;
        drop_vec = '0;
        drops    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            zero_sup[i] = ZERO_SUPPRESS_MASK[i] && (wr_addr_in[i*ADDR_W +: ADDR_W] == '0);
            wr_en_d[i]  = wr_en_req_in[i] & ~kill & ~stall_in & ~zero_sup[i];
            drop_vec[i] = wr_en_req_in[i] & kill & ~stall_in;
            drops       = drops + DW'(drop_vec[i]);
        end
    end

    // Saturating accumulate; the extra sum bit flags overflow.
    always_comb begin
        cnt_sum      = {1'b0, killed_cnt_q} + SW'(drops);
        killed_cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            kill_cnt_q    <= '0;
            kill_active_q <= 1'b0;
            wr_en_q       <= '0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            killed_cnt_q  <= '0;
        end else begin
            kill_cnt_q    <= kill_cnt_d;
            kill_active_q <= (kill_cnt_d != '0);
            wr_en_q       <= wr_en_d;
            killed_cnt_q  <= killed_cnt_d;
            if (!stall_in) begin
                wr_addr_q <= wr_addr_in;
                wr_data_q <= wr_data_in;
            end
        end
    end

    assign wr_en_out       = wr_en_q;
    assign wr_addr_out     = wr_addr_q;
    assign wr_data_out     = wr_data_q;
    assign kill_active_out = kill_active_q;
    assign killed_cnt_out  = killed_cnt_q;

endmodule

// File: tb/tb_msrv32_wr_en_ctrl.sv
// Bench for msrv32_wr_en_ctrl: three instances (KILL=1, KILL=3, CNT_W=4) share stimulus
// and are checked against directed expectations and a cycle-level behavioural model.
module tb_msrv32_wr_en_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        flush_in;
    logic        stall_in;
    logic [1:0]  req;
    logic [23:0] addr;
    logic [63:0] data;

    logic [1:0]  en_o   [3];
    logic [23:0] addr_o [3];
    logic [63:0] data_o [3];
    logic        ka_o   [3];
    logic [15:0] cnt_o  [3];
    logic [15:0] cnt_a, cnt_b;
    logic [3:0]  cnt_c;

    int n_pass  = 0;
    int n_total = 0;

    // reference model state per instance
    int          kc_tab   [3] = '{1, 3, 1};
    int          cmax_tab [3] = '{65535, 65535, 15};
    int          m_kc     [3];
    int          m_cnt    [3];
    bit          m_ka     [3];
    logic [1:0]  m_en     [3];
    logic [23:0] m_addr   [3];
    logic [63:0] m_data   [3];

    always #5 clk_in = ~clk_in;

    assign cnt_o[0] = cnt_a;
    assign cnt_o[1] = cnt_b;
    assign cnt_o[2] = {12'd0, cnt_c};

    msrv32_wr_en_ctrl #(.KILL_CYCLES(1), .CNT_W(16)) u_k1 (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .flush_in(flush_in), .stall_in(stall_in),
        .wr_en_req_in(req), .wr_addr_in(addr), .wr_data_in(data),
        .wr_en_out(en_o[0]), .wr_addr_out(addr_o[0]), .wr_data_out(data_o[0]),
        .kill_active_out(ka_o[0]), .killed_cnt_out(cnt_a));

    msrv32_wr_en_ctrl #(.KILL_CYCLES(3), .CNT_W(16)) u_k3 (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .flush_in(flush_in), .stall_in(stall_in),
        .wr_en_req_in(req), .wr_addr_in(addr), .wr_data_in(data),
        .wr_en_out(en_o[1]), .wr_addr_out(addr_o[1]), .wr_data_out(data_o[1]),
        .kill_active_out(ka_o[1]), .killed_cnt_out(cnt_b));

    msrv32_wr_en_ctrl #(.KILL_CYCLES(1), .CNT_W(4)) u_sat (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .flush_in(flush_in), .stall_in(stall_in),
        .wr_en_req_in(req), .wr_addr_in(addr), .wr_data_in(data),
        .wr_en_out(en_o[2]), .wr_addr_out(addr_o[2]), .wr_data_out(data_o[2]),
        .kill_active_out(ka_o[2]), .killed_cnt_out(cnt_c));

    task automatic m_reset();
        for (int k = 0; k < 3; k++) begin
            m_kc[k] = 0; m_cnt[k] = 0; m_ka[k] = 1'b0;
            m_en[k] = '0; m_addr[k] = '0; m_data[k] = '0;
        end
    endtask

    // One clock of the behavioural model, from the rules: a request is dropped when
    // the window is open (flush now or cycles remaining) and the stage is not stalled.
    task automatic m_step();
        for (int k = 0; k < 3; k++) begin
            bit kill_now;
            int drops;
            kill_now = flush_in || (m_kc[k] > 0);
            drops    = 0;
            m_en[k]  = 2'b00;
            if (!stall_in) begin
                for (int p = 0; p < 2; p++) begin
                    if (req[p]) begin
                        if (kill_now) drops++;
                        else if (!(p == 0 && addr[p*12 +: 12] == 12'd0)) m_en[k][p] = 1'b1;
                    end
                end
                m_addr[k] = addr;
                m_data[k] = data;
                m_cnt[k]  = (m_cnt[k] + drops > cmax_tab[k]) ? cmax_tab[k] : m_cnt[k] + drops;
            end
            if (flush_in)       m_kc[k] = kc_tab[k];
            else if (m_kc[k] > 0) m_kc[k] = m_kc[k] - 1;
            m_ka[k] = (m_kc[k] != 0);
        end
    endtask

    task automatic cyc();
        m_step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0; flush_in = 1'b0; stall_in = 1'b0; req = '0; addr = '0; data = '0;
        m_reset();
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0; flush_in = 1'b0; stall_in = 1'b0;
        req = 2'b11; addr = {12'd7, 12'd5}; data = {32'h1111_2222, 32'h3333_4444};
        m_reset();
        repeat (3) @(posedge clk_in);
        #1;
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if ({en_o[k], addr_o[k], data_o[k], ka_o[k], cnt_o[k]} !== '0)
                $display("FAIL reset_outputs inst=%0d en=%b addr=%h data=%h ka=%b cnt=%0d, want all 0",
                         k, en_o[k], addr_o[k], data_o[k], ka_o[k], cnt_o[k]);
            else n_pass++;
        end
        rst_n_in = 1'b1;
        req = 2'b01; addr = {12'd9, 12'd5}; data = {32'h0000_1234, 32'h0000_DEAD};
        cyc();
        n_total++;
        if (en_o[0] !== 2'b01) $display("FAIL first_en got=%b want=01", en_o[0]);
        else n_pass++;
        n_total++;
        if (addr_o[0][11:0] !== 12'd5 || data_o[0][31:0] !== 32'h0000_DEAD)
            $display("FAIL first_addr_data got=%h/%h want=005/0000dead", addr_o[0][11:0], data_o[0][31:0]);
        else n_pass++;
    endtask

    task automatic test_flush_window();
        do_reset();
        req = 2'b11; addr = {12'h003, 12'h004}; data = 64'h0123_4567_89AB_CDEF;
        repeat (3) cyc();
        flush_in = 1'b1;
        cyc();
        n_total++;
        if (en_o[0] !== 2'b00 || ka_o[0] !== 1'b1)
            $display("FAIL flush_cycle en=%b ka=%b want en=00 ka=1", en_o[0], ka_o[0]);
        else n_pass++;
        flush_in = 1'b0;
        cyc();
        n_total++;
        if (en_o[0] !== 2'b00 || ka_o[0] !== 1'b0)
            $display("FAIL kill_cycle en=%b ka=%b want en=00 ka=0", en_o[0], ka_o[0]);
        else n_pass++;
        cyc();
        n_total++;
        if (en_o[0] !== 2'b11 || cnt_o[0] !== 16'd4)
            $display("FAIL flush_resume en=%b cnt=%0d want en=11 cnt=4", en_o[0], cnt_o[0]);
        else n_pass++;
    endtask

    task automatic test_reflush();
        do_reset();
        req = 2'b11; addr = {12'h010, 12'h020}; data = 64'hFEED_FACE_CAFE_BEEF;
        cyc();
        for (int s = 0; s < 7; s++) begin
            logic [1:0] exp_en;
            flush_in = (s == 0 || s == 2);
            exp_en = (s < 6) ? 2'b00 : 2'b11;
            cyc();
            n_total++;
            if (en_o[1] !== exp_en) $display("FAIL reflush_en step=%0d got=%b want=%b", s, en_o[1], exp_en);
            else n_pass++;
        end
        flush_in = 1'b0;
        n_total++;
        if (cnt_o[1] !== 16'd12) $display("FAIL reflush_cnt got=%0d want=12", cnt_o[1]);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [23:0] a0;
        logic [63:0] d0;
        do_reset();
        a0 = {12'h0AB, 12'h0CD}; d0 = 64'hAAAA_5555_1234_5678;
        req = 2'b11; addr = a0; data = d0;
        cyc();
        stall_in = 1'b1;
        for (int s = 0; s < 3; s++) begin
            req = 2'($urandom); addr = 24'($urandom); data = {$urandom, $urandom};
            cyc();
            n_total++;
            if (en_o[0] !== 2'b00 || addr_o[0] !== a0 || data_o[0] !== d0 || cnt_o[0] !== 16'd0)
                $display("FAIL stall_hold step=%0d en=%b addr=%h data=%h cnt=%0d want 00/%h/%h/0",
                         s, en_o[0], addr_o[0], data_o[0], cnt_o[0], a0, d0);
            else n_pass++;
        end
        flush_in = 1'b1; req = 2'b11;
        cyc();
        n_total++;
        if (cnt_o[0] !== 16'd0 || ka_o[0] !== 1'b1 || en_o[0] !== 2'b00)
            $display("FAIL flush_stall cnt=%0d ka=%b en=%b want 0/1/00", cnt_o[0], ka_o[0], en_o[0]);
        else n_pass++;
        flush_in = 1'b0; stall_in = 1'b0; addr = {12'h001, 12'h002};
        cyc();
        n_total++;
        if (en_o[0] !== 2'b00 || cnt_o[0] !== 16'd2)
            $display("FAIL post_flush_stall en=%b cnt=%0d want 00/2", en_o[0], cnt_o[0]);
        else n_pass++;
        cyc();
        n_total++;
        if (en_o[0] !== 2'b11) $display("FAIL stall_resume en=%b want 11", en_o[0]);
        else n_pass++;
    endtask

    task automatic test_x0();
        do_reset();
        req = 2'b01; addr = {12'h005, 12'h000}; data = 64'h1;
        cyc();
        n_total++;
        if (en_o[0] !== 2'b00 || cnt_o[0] !== 16'd0)
            $display("FAIL x0_port0 en=%b cnt=%0d want 00/0", en_o[0], cnt_o[0]);
        else n_pass++;
        req = 2'b10; addr = {12'h000, 12'h005};
        cyc();
        n_total++;
        if (en_o[0] !== 2'b10) $display("FAIL x0_port1 en=%b want 10", en_o[0]);
        else n_pass++;
        req = 2'b11; addr = 24'h0;
        cyc();
        n_total++;
        if (en_o[0] !== 2'b10 || cnt_o[0] !== 16'd0)
            $display("FAIL x0_both en=%b cnt=%0d want 10/0", en_o[0], cnt_o[0]);
        else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        req = 2'b01; addr = {12'h001, 12'h001}; data = 64'h2; flush_in = 1'b1;
        repeat (20) cyc();
        n_total++;
        if (cnt_o[2] !== 16'd15) $display("FAIL sat_cnt got=%0d want=15", cnt_o[2]);
        else n_pass++;
        n_total++;
        if (cnt_o[0] !== 16'd20) $display("FAIL nosat_cnt got=%0d want=20", cnt_o[0]);
        else n_pass++;
        flush_in = 1'b0;
        #2;
        rst_n_in = 1'b0;
        m_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (ka_o[k] !== 1'b0 || cnt_o[k] !== 16'd0 || en_o[k] !== 2'b00)
                $display("FAIL async_reset inst=%0d ka=%b cnt=%0d en=%b want 0/0/00", k, ka_o[k], cnt_o[k], en_o[k]);
            else n_pass++;
        end
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        req = 2'b01; addr = {12'h001, 12'h00F};
        cyc();
        n_total++;
        if (en_o[1] !== 2'b01 || ka_o[1] !== 1'b0)
            $display("FAIL post_reset_nokill en=%b ka=%b want 01/0", en_o[1], ka_o[1]);
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            flush_in = ($urandom_range(0, 7) == 0);
            stall_in = ($urandom_range(0, 5) == 0);
            req      = 2'($urandom);
            addr[11:0]  = ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom);
            addr[23:12] = ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom);
            data     = {$urandom, $urandom};
            cyc();
            for (int k = 0; k < 3; k++) begin
                n_total++;
                if (en_o[k] !== m_en[k] || ka_o[k] !== m_ka[k])
                    $display("FAIL rand_en c=%0d inst=%0d en=%b ka=%b want %b/%b", c, k, en_o[k], ka_o[k], m_en[k], m_ka[k]);
                else n_pass++;
                n_total++;
                if (addr_o[k] !== m_addr[k] || data_o[k] !== m_data[k])
                    $display("FAIL rand_bus c=%0d inst=%0d addr=%h data=%h want %h/%h", c, k, addr_o[k], data_o[k], m_addr[k], m_data[k]);
                else n_pass++;
                n_total++;
                if (cnt_o[k] !== 16'(m_cnt[k]))
                    $display("FAIL rand_cnt c=%0d inst=%0d got=%0d want=%0d", c, k, cnt_o[k], m_cnt[k]);
                else n_pass++;
            end
        end
        flush_in = 1'b0; stall_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_flush_window();
        test_reflush();
        test_stall();
        test_x0();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
